frame_parity_unit: RTL and testbench
====================================

# frame_parity_unit

Streaming parity generator/checker, the parametrised successor to the team's fixed four-input parity gates. It accepts DATA_W-bit words over a valid/ready handshake and accumulates parity across a frame of up to FRAME_LEN words. Per frame it emits one registered result: a parity bit in generate mode, or a pass/fail flag in check mode. It sits between a word source and a frame sink as a single-clock, backpressure-aware stage.

## Interface
- DATA_W, 4, input word width (≥1)
- FRAME_LEN, 8, maximum words per frame (≥1); reaching it closes the frame
- ODD_PAR, 1, 1: parity bit makes total ones odd (XNOR reduction); 0: even (XOR reduction)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  1  0 = generate, 1 = check; sampled on the first accepted word of a frame
- in_valid  in  1  word present
- in_ready  out  1  unit can accept a word
- in_data  in  DATA_W  word
- in_last  in  1  early frame close, qualified with in_valid
- in_par  in  1  expected parity, check mode only, sampled with the closing word
- out_valid  out  1  frame result pending
- out_ready  in  1  sink accepts result
- out_parity  out  1  computed frame parity bit
- out_error  out  1  check mode: computed ≠ in_par; always 0 in generate mode
- out_count  out  $clog2(FRAME_LEN+1)  number of words in the frame

## Operation
- States: IDLE (no frame open), ACCUM (frame open), HOLD (result pending).
- Accept = in_valid & in_ready at the rising edge; in_ready = (state != HOLD).
- IDLE, accept: start frame, latch mode, acc = reduction of word, count = 1 → ACCUM; or → HOLD immediately if in_last or FRAME_LEN == 1.
- ACCUM, accept: acc ^= word reduction, count++; closing word (in_last or count reaches FRAME_LEN) → HOLD.
- On close: out_parity = acc ^ ODD_PAR over all accepted bits; out_error = latched_mode & (out_parity != in_par); out_count = count.
- HOLD: outputs stable until out_valid & out_ready, then → IDLE.
- in_last asserted without in_valid is ignored; mode changes mid-frame are ignored.
- No idle timeout: an open frame waits indefinitely for words.
- rst at any point, including mid-frame or in HOLD, discards the frame and returns to IDLE.
- Reset values: in_ready = 1, out_valid = 0, out_parity = 0, out_error = 0, out_count = 0, internal state IDLE.

## Timing
- out_valid rises on the edge that accepts the closing word, visible the next cycle; latency is 1 cycle from the closing accept.
- in_ready is low for every HOLD cycle.
- The cycle after the result handshake is IDLE with in_ready = 1, giving a minimum 1-cycle bubble between frames.
- Throughput inside a frame is one word per cycle.
- out_valid is never deasserted without an out_ready handshake, except by rst.

## Configuration
- FRAME_PARITY_COLUMN_EN defined: adds output out_col [DATA_W-1:0], the per-bit-position (column) parity across the frame with the same ODD_PAR polarity. It is valid and held with out_valid, and resets to 0.
- FRAME_PARITY_COLUMN_EN undefined: the port and its DATA_W-bit accumulator are absent; all other behaviour is identical.

## Structure
- Shared package parity_pkg holds:
  - the state enum (IDLE, ACCUM, HOLD);
  - mode constants MODE_GEN = 0 and MODE_CHECK = 1;
  - a function for the count width.
- Sub-module word_parity: parametrised combinational reduction of one DATA_W word (XOR), instantiated once. Polarity is applied at close, not per word.

## Test plan
- DATA_W = 4, FRAME_LEN = 4, ODD_PAR = 1, generate; words 1, 2, 4, 8 back-to-back → out_valid 1 cycle after 4th accept, out_parity = 1, out_count = 4, out_error = 0.
- Check mode, words F, 1, in_last on 2nd word, in_par = 0 → total ones 5, out_parity = 0, out_error = 0, out_count = 2; repeat with in_par = 1 → out_error = 1.
- Hold out_ready = 0 for 5 cycles after close → in_ready = 0 and outputs stable throughout; release → IDLE with in_ready = 1 the next cycle.
- Assert rst mid-frame after 2 words, then send a new 4-word frame of 0s → no stale result; out_parity = 1, out_count = 4; all outputs at reset values while rst is high.
- Toggle mode and pulse in_last with in_valid = 0 mid-frame → no effect; FRAME_LEN = 1 → every accepted word closes its own frame.
- With FRAME_PARITY_COLUMN_EN: words 3, 5 frame of 2 → out_col = ~(3^5) & F = 9.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and constants for the frame parity unit: FSM state encoding,
// mode values and the result-count width helper.
package parity_pkg;

  // Frame lifecycle: nothing open, words being folded in, result waiting.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic MODE_GEN   = 1'b0;
  localparam logic MODE_CHECK = 1'b1;

  // Width needed to hold a word count from 0 up to and including frame_len.
  function automatic int count_w(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/frame_parity_unit_if.sv
// Word-in / result-out bundle of the frame parity unit.
// Optional macro FRAME_PARITY_COLUMN_EN adds the out_col column-parity field.
//
// Handshake: a word moves when in_valid and in_ready are both high at a rising
// clock edge; a result moves when out_valid and out_ready are both high at a
// rising edge. A producer holding valid high keeps its payload stable until the
// transfer, and the unit never drops out_valid before the result is taken.
interface frame_parity_unit_if #(
  parameter int DATA_W    = 4,
  parameter int FRAME_LEN = 8
);
  localparam int CNT_W = parity_pkg::count_w(FRAME_LEN);

  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_par;
  logic              out_valid;
  logic              out_ready;
  logic              out_parity;
  logic              out_error;
  logic [CNT_W-1:0]  out_count;
`ifdef FRAME_PARITY_COLUMN_EN
  logic [DATA_W-1:0] out_col;

  modport master (
    output mode, in_valid, in_data, in_last, in_par, out_ready,
    input  in_ready, out_valid, out_parity, out_error, out_count, out_col
  );

  modport slave (
    input  mode, in_valid, in_data, in_last, in_par, out_ready,
    output in_ready, out_valid, out_parity, out_error, out_count, out_col
  );
`else
  modport master (
    output mode, in_valid, in_data, in_last, in_par, out_ready,
    input  in_ready, out_valid, out_parity, out_error, out_count
  );

  modport slave (
    input  mode, in_valid, in_data, in_last, in_par, out_ready,
    output in_ready, out_valid, out_parity, out_error, out_count
  );
`endif

endinterface

// File: rtl/word_parity.sv
// XOR reduction of a single word. Polarity (odd/even) is applied once when the
// frame closes, so this stays a plain parity tree.
module word_parity #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              par_o
);

  assign par_o = ^data_i;

endmodule

// File: rtl/frame_parity_unit.sv
// Streaming frame parity generator/checker.
// Folds up to FRAME_LEN words into one parity bit and presents a registered
// per-frame result (parity, check error, word count) until the sink takes it.
// Optional macro FRAME_PARITY_COLUMN_EN adds per-bit-position parity (out_col).
module frame_parity_unit
  import parity_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int FRAME_LEN = 8,
  parameter int ODD_PAR   = 1
) (
  input  logic                clk,
  input  logic                rst,
  frame_parity_unit_if.slave  bus,
  output state_t              dbg_state_o
);

  localparam int               CNT_W    = count_w(FRAME_LEN);
  localparam logic             POL      = (ODD_PAR != 0);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic             word_red;
  logic             accept;
  logic             closing;
  logic             load_res;
  logic             acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             mode_nxt;
  logic             par_nxt;

  word_parity #(.DATA_W(DATA_W)) u_word_parity (
    .data_i (bus.in_data),
    .par_o  (word_red)
  );

  // Only IDLE/ACCUM raise in_ready, so an accept always folds into a frame.
  assign accept   = bus.in_valid & bus.in_ready;
  assign load_res = accept & closing;

  // What the running frame becomes if the current word is accepted; the first
  // word of a frame restarts the fold and samples mode.
  always_comb begin
    acc_nxt  = acc_q ^ word_red;
    cnt_nxt  = cnt_q + CNT_W'(1);
    mode_nxt = mode_q;
    if (state_q == IDLE) begin
      acc_nxt  = word_red;
      cnt_nxt  = CNT_W'(1);
      mode_nxt = bus.mode;
    end
    closing = bus.in_last | (cnt_nxt == LAST_CNT);
    par_nxt = acc_nxt ^ POL;
  end

  // FSM next state and datapath loads.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    err_d     = err_q;
    out_cnt_d = out_cnt_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          mode_d  = mode_nxt;
          acc_d   = acc_nxt;
          cnt_d   = cnt_nxt;
          state_d = ACCUM;
          if (closing) begin
            state_d   = HOLD;
            par_d     = par_nxt;
            err_d     = (mode_nxt == MODE_CHECK) & (par_nxt != bus.in_par);
            out_cnt_d = cnt_nxt;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset discards any open or pending frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_GEN;
      acc_q     <= 1'b0;
      cnt_q     <= '0;
      par_q     <= 1'b0;
      err_q     <= 1'b0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      par_q     <= par_d;
      err_q     <= err_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign bus.in_ready   = (state_q != HOLD);
  assign bus.out_valid  = (state_q == HOLD);
  assign bus.out_parity = par_q;
  assign bus.out_error  = err_q;
  assign bus.out_count  = out_cnt_q;
  assign dbg_state_o    = state_q;

`ifdef FRAME_PARITY_COLUMN_EN
  logic [DATA_W-1:0] col_acc_q, col_acc_d;
  logic [DATA_W-1:0] col_q, col_d;
  logic [DATA_W-1:0] col_nxt;

  // Column fold mirrors the scalar fold, one parity bit per bit position.
  always_comb begin
    col_nxt   = (state_q == IDLE) ? bus.in_data : (col_acc_q ^ bus.in_data);
    col_acc_d = accept ? col_nxt : col_acc_q;
    col_d     = load_res ? (col_nxt ^ {DATA_W{POL}}) : col_q;
  end

  // Column accumulator and held column result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_acc_q <= '0;
      col_q     <= '0;
    end else begin
      col_acc_q <= col_acc_d;
      col_q     <= col_d;
    end
  end

  assign bus.out_col = col_q;
`endif

endmodule

// File: tb/tb_frame_parity_unit.sv
// Directed bench for frame_parity_unit: a FRAME_LEN=4 unit for the main
// scenarios and a FRAME_LEN=1 unit for single-word frames.
module tb_frame_parity_unit;
  import parity_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg0, dbg1;
  int     checks;
  int     errors;

  frame_parity_unit_if #(.DATA_W(4), .FRAME_LEN(4)) bus ();
  frame_parity_unit_if #(.DATA_W(4), .FRAME_LEN(1)) bus1 ();

  frame_parity_unit #(.DATA_W(4), .FRAME_LEN(4), .ODD_PAR(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg0)
  );

  frame_parity_unit #(.DATA_W(4), .FRAME_LEN(1), .ODD_PAR(1)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus1.slave),
    .dbg_state_o (dbg1)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic drive_word(input logic [3:0] data, input logic last,
                            input logic par, input logic md);
    bus.in_data  = data;
    bus.in_last  = last;
    bus.in_par   = par;
    bus.mode     = md;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: ready=%b valid=%b exp ready=1 valid=0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.out_parity !== 1'b0 || bus.out_error !== 1'b0 || bus.out_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: par=%b err=%b cnt=%0d exp 0/0/0", bus.out_parity, bus.out_error, bus.out_count);
    end
    checks++;
    if (dbg0 !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d exp %0d", dbg0, IDLE);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_generate();
    drive_word(4'h1, 1'b0, 1'b0, MODE_GEN);
    drive_word(4'h2, 1'b0, 1'b0, MODE_GEN);
    drive_word(4'h4, 1'b0, 1'b0, MODE_GEN);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL gen_early_valid: got %b exp 0", bus.out_valid);
    end
    drive_word(4'h8, 1'b0, 1'b0, MODE_GEN);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_parity !== 1'b1 || bus.out_count !== 3'd4 || bus.out_error !== 1'b0) begin
      errors++;
      $display("FAIL gen_result: valid=%b par=%b cnt=%0d err=%b exp 1/1/4/0",
               bus.out_valid, bus.out_parity, bus.out_count, bus.out_error);
    end
    release_result();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL gen_release: ready=%b valid=%b exp 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_check();
    // F,1 -> five ones, odd parity bit 0
    drive_word(4'hF, 1'b0, 1'b0, MODE_CHECK);
    drive_word(4'h1, 1'b1, 1'b0, MODE_CHECK);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_parity !== 1'b0 || bus.out_error !== 1'b0 || bus.out_count !== 3'd2) begin
      errors++;
      $display("FAIL check_match: valid=%b par=%b err=%b cnt=%0d exp 1/0/0/2",
               bus.out_valid, bus.out_parity, bus.out_error, bus.out_count);
    end
    release_result();
    drive_word(4'hF, 1'b0, 1'b0, MODE_CHECK);
    drive_word(4'h1, 1'b1, 1'b1, MODE_CHECK);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_parity !== 1'b0 || bus.out_error !== 1'b1 || bus.out_count !== 3'd2) begin
      errors++;
      $display("FAIL check_mismatch: valid=%b par=%b err=%b cnt=%0d exp 1/0/1/2",
               bus.out_valid, bus.out_parity, bus.out_error, bus.out_count);
    end
    release_result();
  endtask

  task automatic test_hold();
    drive_word(4'h1, 1'b0, 1'b0, MODE_GEN);
    drive_word(4'h2, 1'b0, 1'b0, MODE_GEN);
    drive_word(4'h4, 1'b0, 1'b0, MODE_GEN);
    drive_word(4'h8, 1'b0, 1'b0, MODE_GEN);
    // Offer a word during the stall; it must not be taken.
    bus.in_data  = 4'h7;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || dbg0 !== HOLD) begin
        errors++;
        $display("FAIL hold_ready[%0d]: ready=%b state=%0d exp 0/%0d", i, bus.in_ready, dbg0, HOLD);
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_parity !== 1'b1 || bus.out_count !== 3'd4 || bus.out_error !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: valid=%b par=%b cnt=%0d err=%b exp 1/1/4/0",
                 i, bus.out_valid, bus.out_parity, bus.out_count, bus.out_error);
      end
    end
    bus.in_valid = 1'b0;
    release_result();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || dbg0 !== IDLE) begin
      errors++;
      $display("FAIL hold_release: ready=%b valid=%b state=%0d exp 1/0/%0d", bus.in_ready, bus.out_valid, dbg0, IDLE);
    end
  endtask

  task automatic test_reset_mid();
    drive_word(4'hF, 1'b0, 1'b0, MODE_CHECK);
    drive_word(4'hF, 1'b0, 1'b0, MODE_CHECK);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_parity !== 1'b0 ||
        bus.out_error !== 1'b0 || bus.out_count !== 3'd0 || dbg0 !== IDLE) begin
      errors++;
      $display("FAIL rst_mid_values: ready=%b valid=%b par=%b err=%b cnt=%0d state=%0d exp 1/0/0/0/0/IDLE",
               bus.in_ready, bus.out_valid, bus.out_parity, bus.out_error, bus.out_count, dbg0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_word(4'h0, 1'b0, 1'b0, MODE_GEN);
    drive_word(4'h0, 1'b0, 1'b0, MODE_GEN);
    drive_word(4'h0, 1'b0, 1'b0, MODE_GEN);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_stale: valid=%b exp 0", bus.out_valid);
    end
    drive_word(4'h0, 1'b0, 1'b0, MODE_GEN);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_parity !== 1'b1 || bus.out_count !== 3'd4 || bus.out_error !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_frame: valid=%b par=%b cnt=%0d err=%b exp 1/1/4/0",
               bus.out_valid, bus.out_parity, bus.out_count, bus.out_error);
    end
    release_result();
  endtask

  task automatic test_mode_ignore();
    drive_word(4'h3, 1'b0, 1'b0, MODE_GEN);
    bus.mode    = MODE_CHECK;
    bus.in_last = 1'b1;
    @(posedge clk);
    #1;
    bus.in_last = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || dbg0 !== ACCUM) begin
      errors++;
      $display("FAIL ignore_last: valid=%b state=%0d exp 0/%0d", bus.out_valid, dbg0, ACCUM);
    end
    drive_word(4'h1, 1'b0, 1'b0, MODE_CHECK);
    drive_word(4'h7, 1'b0, 1'b0, MODE_CHECK);
    drive_word(4'h0, 1'b0, 1'b0, MODE_CHECK);
    // six ones -> parity 1; frame is still generate mode so no error
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_parity !== 1'b1 || bus.out_error !== 1'b0 || bus.out_count !== 3'd4) begin
      errors++;
      $display("FAIL ignore_mode: valid=%b par=%b err=%b cnt=%0d exp 1/1/0/4",
               bus.out_valid, bus.out_parity, bus.out_error, bus.out_count);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    drive_word(4'h6, 1'b1, 1'b0, MODE_GEN);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_parity !== 1'b1 || bus.out_count !== 3'd1) begin
      errors++;
      $display("FAIL b2b_first: valid=%b par=%b cnt=%0d exp 1/1/1", bus.out_valid, bus.out_parity, bus.out_count);
    end
    release_result();
    drive_word(4'hA, 1'b1, 1'b0, MODE_CHECK);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_parity !== 1'b1 || bus.out_error !== 1'b1 || bus.out_count !== 3'd1) begin
      errors++;
      $display("FAIL b2b_second: valid=%b par=%b err=%b cnt=%0d exp 1/1/1/1",
               bus.out_valid, bus.out_parity, bus.out_error, bus.out_count);
    end
    release_result();
  endtask

  task automatic test_frame_len1();
    bus1.in_data  = 4'h7;
    bus1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    checks++;
    if (bus1.out_valid !== 1'b1 || bus1.out_parity !== 1'b0 || bus1.out_count !== 1'b1 || dbg1 !== HOLD) begin
      errors++;
      $display("FAIL len1_first: valid=%b par=%b cnt=%0d state=%0d exp 1/0/1/HOLD",
               bus1.out_valid, bus1.out_parity, bus1.out_count, dbg1);
    end
    bus1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus1.out_ready = 1'b0;
    bus1.in_data   = 4'h5;
    bus1.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    checks++;
    if (bus1.out_valid !== 1'b1 || bus1.out_parity !== 1'b1 || bus1.out_count !== 1'b1) begin
      errors++;
      $display("FAIL len1_second: valid=%b par=%b cnt=%0d exp 1/1/1", bus1.out_valid, bus1.out_parity, bus1.out_count);
    end
    bus1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus1.out_ready = 1'b0;
  endtask

`ifdef FRAME_PARITY_COLUMN_EN
  task automatic test_column();
    drive_word(4'h3, 1'b0, 1'b0, MODE_GEN);
    drive_word(4'h5, 1'b1, 1'b0, MODE_GEN);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_col !== 4'h9 || bus.out_parity !== 1'b1) begin
      errors++;
      $display("FAIL column: valid=%b col=%h par=%b exp 1/9/1", bus.out_valid, bus.out_col, bus.out_parity);
    end
    release_result();
  endtask
`endif

  // ---------------- sequence ----------------
  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.mode       = MODE_GEN;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.in_par     = 1'b0;
    bus.out_ready  = 1'b0;
    bus1.mode      = MODE_GEN;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = '0;
    bus1.in_last   = 1'b0;
    bus1.in_par    = 1'b0;
    bus1.out_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_generate();
    test_check();
    test_hold();
    test_reset_mid();
    test_mode_ignore();
    test_back_to_back();
    test_frame_len1();
`ifdef FRAME_PARITY_COLUMN_EN
    test_column();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
